phase_frame_ctrl: RTL
=====================

# phase_frame_ctrl

Sequencer between the proto245 RX FIFO and the per-channel PWM phase inputs. Pulls host bytes, parses phase-frame and enable-mask packets into a shadow bank, and commits the bank atomically on the next PWM period boundary, so all channels change phase in the same carrier cycle. Replaces the free-running per-byte phase_parser path and returns ACK/NAK bytes through the TX FIFO.

## Interface
- NUM_CHANNELS, 4, channel count (1..8)
- PHASE_W, 8, phase width; CLK_CNT_MAX = 256 at 10.24 MHz / 40 kHz
- PHASE_MAX, 255, largest legal phase value
- TIMEOUT_CYCLES, 1024, max idle cycles between payload bytes
- sys_clk  in  1  single clock; every port is synchronous to it
- sys_rst  in  1  synchronous, active-high reset
- rxfifo_data  in  8  RX FIFO read data
- rxfifo_valid  in  1  read data valid, exactly 1 cycle after rxfifo_rd
- rxfifo_empty  in  1  RX FIFO empty
- rxfifo_rd  out  1  RX FIFO read strobe
- txfifo_full  in  1  TX FIFO full
- txfifo_wr  out  1  TX FIFO write strobe
- txfifo_data  out  8  ACK/NAK byte
- period_start  in  1  1-cycle pulse per PWM period, already synchronized into sys_clk
- phases  out  NUM_CHANNELS x PHASE_W  active phases to PWM synchronizer
- pwm_en  out  NUM_CHANNELS  active channel enables
- commit  out  1  1-cycle pulse when the shadow bank is copied to active
- frame_err  out  1  1-cycle pulse on rejected or aborted packet
- busy  out  1  high in any state other than IDLE

## Operation
- Packets: 0xA5 + NUM_CHANNELS phase bytes (channel 0 first); 0x5A + 1 mask byte (bit i enables channel i; upper bits ignored); 0x0F (stop) with no payload, which loads an all-zero mask.
- Any other header byte: consumed, frame_err pulse, NAK, return to IDLE.
- FSM states:
  - IDLE: if !rxfifo_empty, assert rxfifo_rd and go to HDR.
  - HDR: wait for rxfifo_valid, then decode. A5 or 5A goes to PAYLOAD with byte index cleared. 0F goes to CHECK. Any other value goes to IDLE (error path).
  - PAYLOAD: with no read outstanding and !rxfifo_empty, assert rxfifo_rd. On valid, store the byte at the current index and increment the index. After the last byte, go to CHECK.
  - CHECK: validate, then load the shadow bank or reject. Return to IDLE.
- At most one read outstanding; rxfifo_rd is never asserted while rxfifo_empty is high.
- Validation:
  - Any phase > PHASE_MAX rejects the whole frame. The shadow bank is unchanged, frame_err pulses, NAK is sent.
  - On acceptance, only the fields carried by the packet type are written into the shadow; the pending flag is set and ACK is sent.
- Timeout: in PAYLOAD, a counter counts cycles without valid and resets on each valid. At TIMEOUT_CYCLES the partial packet is discarded, frame_err pulses, NAK is sent, FSM goes to IDLE.
- Commit: on period_start with pending set, phases and pwm_en load from the shadow, commit pulses, pending clears. On period_start without pending, nothing happens.
- Overwrite: a new accept while pending replaces the shadow contents (latest wins); still one commit.
- ACK = 0x06, NAK = 0x15, one txfifo_wr cycle each. If txfifo_full, the byte is dropped; the FSM never stalls on TX.

## Timing
- Reset values:
  - outputs: phases all 0, pwm_en all 1, rxfifo_rd/txfifo_wr/commit/frame_err/busy all 0, txfifo_data 0
  - internal: shadow = reset values, pending 0, FSM IDLE
- Reset mid-packet discards partial data; rxfifo_rd is 0 during the reset cycle.
- Phase frame with a non-empty FIFO:
  - header rd at cycle 0, header valid at 1
  - payload byte k: rd at 2+2k, valid at 3+2k
  - CHECK at 2N+2; pending, ACK and frame_err are registered out at 2N+3 (cycle 11 for N=4)
- Commit: phases/pwm_en update and commit pulses in the cycle after the period_start cycle (1-cycle latency).
- Accept and period_start in the same cycle: period_start sees the pre-accept pending and shadow. The new frame stays pending for the next period.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates. The byte index is $clog2(NUM_CHANNELS+1) wide.

## Structure
- Shared package holo_pkg holds:
  - CMD_PHASE=0xA5, CMD_MASK=0x5A, CMD_STOP=0x0F, RSP_ACK=0x06, RSP_NAK=0x15
  - the FSM state enum
  - CLK_CNT_MAX and the derived phase width
- Optional sub-module rx_byte_fetch: owns the rd/valid single-outstanding handshake and the timeout counter. It presents the FSM with byte plus strobe, and timeout.

## Test plan
- Reset, then FIFO bytes A5 10 20 30 40, then period_start at cycle 20 -> phases {0x10,0x20,0x30,0x40} and commit at cycle 21, one ACK 0x06; phases unchanged before cycle 21.
- Two phase frames (A5 01 02 03 04, then A5 05 06 07 08) before any period_start -> one commit carrying 05..08, two ACKs.
- 5A 05, then 0F, each committed on separate period_start pulses -> pwm_en=0101 after the first commit, 0000 after the second; phases untouched.
- Header 0x77; then A5 10 followed by a 1024-cycle gap -> frame_err and NAK for each; shadow and active bank unchanged; next valid frame accepted.
- PHASE_MAX=200, frame A5 10 C9 30 40 -> rejected with NAK, no commit. Separately, accept coinciding with period_start -> commit only on the following period_start.
- txfifo_full held high through an accepted frame -> txfifo_wr never asserts, frame still commits; sys_rst mid-payload -> all outputs return to reset values.

Source files
------------

// File: rtl/holo_pkg.sv
// Shared command/response codes, FSM state type and carrier-derived widths
// for the phase-frame sequencer.
package holo_pkg;

   localparam logic [7:0] CMD_PHASE = 8'hA5;
   localparam logic [7:0] CMD_MASK  = 8'h5A;
   localparam logic [7:0] CMD_STOP  = 8'h0F;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   // 10.24 MHz system clock over a 40 kHz carrier gives 256 counts per period.
   localparam int CLK_CNT_MAX = 256;
   localparam int PHASE_W_DEF = $clog2(CLK_CNT_MAX);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CHECK   = 2'd3
   } state_t;

   function automatic logic is_payload_cmd(input logic [7:0] b);
      return (b == CMD_PHASE) || (b == CMD_MASK);
   endfunction

endpackage

// File: rtl/rx_byte_fetch.sv
// RX FIFO reader: keeps at most one read outstanding, hands bytes to the
// parser as byte+strobe and flags a payload idle timeout.
module rx_byte_fetch #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       rd_req,
   input  logic       tmo_en,
   input  logic [7:0] rxfifo_data,
   input  logic       rxfifo_valid,
   input  logic       rxfifo_empty,
   output logic       rxfifo_rd,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       timeout
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

   logic          outstanding;
   logic [TW-1:0] idle_cnt;

   // Handshake: rxfifo_rd is a 1-cycle strobe, only while not empty and no
   // read is in flight; rxfifo_valid answers it exactly one cycle later.
   assign rxfifo_rd = rd_req && !outstanding && !rxfifo_empty && !sys_rst;
   assign rx_byte   = rxfifo_data;
   assign rx_strobe = rxfifo_valid && outstanding;
   assign timeout   = tmo_en && !rx_strobe && (idle_cnt == TMO_LIMIT);

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         outstanding <= 1'b0;
      else if (rxfifo_rd)
         outstanding <= 1'b1;
      else if (rxfifo_valid)
         outstanding <= 1'b0;
   end

   // Saturating count of cycles since the last byte while a payload is open.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || !tmo_en || rx_strobe)
         idle_cnt <= '0;
      else if (idle_cnt != TMO_LIMIT)
         idle_cnt <= idle_cnt + 1'b1;
   end

endmodule

// File: rtl/phase_frame_ctrl.sv
// Parses phase/mask/stop packets from the host into a shadow bank and commits
// it to the PWM channels on the next period boundary, answering ACK/NAK.
module phase_frame_ctrl
   import holo_pkg::*;
#(
   parameter int NUM_CHANNELS   = 4,
   parameter int PHASE_W        = PHASE_W_DEF,
   parameter int PHASE_MAX      = 255,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                 sys_clk,
   input  logic                                 sys_rst,
   input  logic [7:0]                           rxfifo_data,
   input  logic                                 rxfifo_valid,
   input  logic                                 rxfifo_empty,
   output logic                                 rxfifo_rd,
   input  logic                                 txfifo_full,
   output logic                                 txfifo_wr,
   output logic [7:0]                           txfifo_data,
   input  logic                                 period_start,
   output logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
   output logic [NUM_CHANNELS-1:0]              pwm_en,
   output logic                                 commit,
   output logic                                 frame_err,
   output logic                                 busy,
   output state_t                               fsm_state
);
   localparam int IDX_W = $clog2(NUM_CHANNELS + 1);
   localparam logic [7:0] PHASE_LIMIT = 8'(PHASE_MAX);

   state_t state, nxt;
   logic       rd_req, tmo_en, rx_strobe, timeout;
   logic [7:0] rx_byte;
   logic [7:0] cmd;
   logic [IDX_W-1:0] idx, last_idx;
   logic [7:0] pay [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0][PHASE_W-1:0] shadow_ph;
   logic [NUM_CHANNELS-1:0] shadow_en;
   logic pending, phase_bad, hdr_bad, pkt_ok, pkt_bad, reject;

   rx_byte_fetch #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fetch (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .rd_req      (rd_req),
      .tmo_en      (tmo_en),
      .rxfifo_data (rxfifo_data),
      .rxfifo_valid(rxfifo_valid),
      .rxfifo_empty(rxfifo_empty),
      .rxfifo_rd   (rxfifo_rd),
      .rx_byte     (rx_byte),
      .rx_strobe   (rx_strobe),
      .timeout     (timeout)
   );

   assign last_idx  = (cmd == CMD_PHASE) ? IDX_W'(NUM_CHANNELS - 1) : '0;
   assign busy      = (state != S_IDLE);
   assign fsm_state = state;
   assign reject    = hdr_bad || pkt_bad;

   always_comb begin
      phase_bad = 1'b0;
      if (cmd == CMD_PHASE)
         for (int i = 0; i < NUM_CHANNELS; i++)
            if (pay[i] > PHASE_LIMIT) phase_bad = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (rxfifo_rd) nxt = S_HDR;
         S_HDR:
            if (rx_strobe) begin
               if (is_payload_cmd(rx_byte))  nxt = S_PAYLOAD;
               else if (rx_byte == CMD_STOP) nxt = S_CHECK;
               else                          nxt = S_IDLE;
            end
         S_PAYLOAD:
            if (timeout)                           nxt = S_IDLE;
            else if (rx_strobe && idx == last_idx) nxt = S_CHECK;
         S_CHECK:   nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_req  = 1'b0;
      tmo_en  = 1'b0;
      hdr_bad = 1'b0;
      pkt_ok  = 1'b0;
      pkt_bad = 1'b0;
      case (state)
         S_IDLE:    rd_req = 1'b1;
         S_HDR:     hdr_bad = rx_strobe && !is_payload_cmd(rx_byte) && (rx_byte != CMD_STOP);
         S_PAYLOAD: begin
            rd_req  = 1'b1;
            tmo_en  = 1'b1;
            pkt_bad = timeout;
         end
         S_CHECK:   begin
            pkt_ok  = !phase_bad;
            pkt_bad = phase_bad;
         end
         default:   ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (state == S_PAYLOAD && rx_strobe)
         for (int i = 0; i < NUM_CHANNELS; i++)
            if (idx == IDX_W'(i)) pay[i] <= rx_byte;
   end

   // Period commit samples the pre-accept pending/shadow; an accept in the
   // same cycle therefore stays pending for the following period.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cmd         <= '0;
         idx         <= '0;
         shadow_ph   <= '0;
         shadow_en   <= '1;
         pending     <= 1'b0;
         phases      <= '0;
         pwm_en      <= '1;
         commit      <= 1'b0;
         frame_err   <= 1'b0;
         txfifo_wr   <= 1'b0;
         txfifo_data <= '0;
      end else begin
         commit    <= 1'b0;
         frame_err <= reject;
         txfifo_wr <= 1'b0;
         if (state == S_HDR && rx_strobe) begin
            cmd <= rx_byte;
            idx <= '0;
         end
         if (state == S_PAYLOAD && rx_strobe)
            idx <= idx + 1'b1;
         if (period_start && pending) begin
            phases  <= shadow_ph;
            pwm_en  <= shadow_en;
            commit  <= 1'b1;
            pending <= 1'b0;
         end
         if (pkt_ok) begin
            pending <= 1'b1;
            if (cmd == CMD_PHASE)
               for (int i = 0; i < NUM_CHANNELS; i++) shadow_ph[i] <= PHASE_W'(pay[i]);
            else if (cmd == CMD_MASK)
               shadow_en <= pay[0][NUM_CHANNELS-1:0];
            else
               shadow_en <= '0;
         end
         // TX never back-pressures the parser: a full FIFO drops the response.
         if ((pkt_ok || reject) && !txfifo_full) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= pkt_ok ? RSP_ACK : RSP_NAK;
         end
      end
   end

endmodule
